// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg
// Shared constants, the fp32 field layout and the add/sub sequencer state
// encoding used by the single-precision adder and its operand parser.
// ----------------------------------------------------------------------------
package fpu_pkg;

    localparam logic [7:0]  EXP_INF = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam int          MANT_W  = 24;              // hidden bit + 23 fraction bits
    localparam int          GRS_W   = 3;               // guard, round, sticky
    localparam int          ALN_W   = MANT_W + GRS_W;  // aligned mantissa width
    localparam int          SUM_W   = ALN_W + 1;       // aligned width plus carry-out

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        IDLE,
        SPECIAL,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } seq_state_t;

    // {1.frac, G=0, R=0, S=0}: a normal operand's significand ready for alignment.
    function automatic logic [ALN_W-1:0] aligned_mant(input fp32_t f);
        return {1'b1, f.frac, {GRS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/operands.sv
// ----------------------------------------------------------------------------
// operands
// Combinational fp32 operand parser. Splits both operands into fields,
// classifies each (zero/denormal, infinity, NaN) and reports which one has
// the larger magnitude together with the exponent distance between them.
//
// Ports
//   x_i, y_i      in   operands (fp32 fields)
//   x_o, y_o      out  decomposed operands
//   x_zero_o ...  out  exp == 0 (zero or denormal, both treated as zero)
//   x_inf_o  ...  out  exp == 0xFF, frac == 0
//   x_nan_o  ...  out  exp == 0xFF, frac != 0
//   x_greater_o   out  |x| >= |y|
//   exp_shift_o   out  |exp_x - exp_y|
// ----------------------------------------------------------------------------
module operands import fpu_pkg::*; (
    input  fp32_t      x_i,
    input  fp32_t      y_i,
    output fp32_t      x_o,
    output fp32_t      y_o,
    output logic       x_zero_o,
    output logic       y_zero_o,
    output logic       x_inf_o,
    output logic       y_inf_o,
    output logic       x_nan_o,
    output logic       y_nan_o,
    output logic       x_greater_o,
    output logic [7:0] exp_shift_o
);

    assign x_o = x_i;
    assign y_o = y_i;

    assign x_zero_o = (x_i.exp == 8'h00);
    assign y_zero_o = (y_i.exp == 8'h00);
    assign x_inf_o  = (x_i.exp == EXP_INF) && (x_i.frac == '0);
    assign y_inf_o  = (y_i.exp == EXP_INF) && (y_i.frac == '0);
    assign x_nan_o  = (x_i.exp == EXP_INF) && (x_i.frac != '0);
    assign y_nan_o  = (y_i.exp == EXP_INF) && (y_i.frac != '0);

    // Exponent-then-fraction ordering is the magnitude ordering for fp32.
    assign x_greater_o = ({x_i.exp, x_i.frac} >= {y_i.exp, y_i.frac});
    assign exp_shift_o = x_greater_o ? (x_i.exp - y_i.exp) : (y_i.exp - x_i.exp);

endmodule

// File: rtl/fpu_add_seq.sv
// ----------------------------------------------------------------------------
// fpu_add_seq
// Multi-cycle IEEE-754 single-precision add/subtract. One operand pair is in
// flight at a time. NaN/infinity/zero operands resolve in one SPECIAL cycle;
// normal operands walk ALIGN -> ADD -> NORM -> ROUND (nearest-even). The
// result is held in DONE until the consumer takes it.
//
// Ports
//   clk_i, rst_n_i   clock (rising edge), asynchronous active-low reset
//   in_valid_i       operand pair valid
//   in_ready_o       idle, a pair is accepted when in_valid_i is high
//   x_i, y_i, sub_i  operands; sub_i=1 computes x - y
//   out_valid_o      result valid (held until out_ready_i)
//   out_ready_i      consumer takes the result
//   result_o         fp32 result
//   invalid_o        inf-inf or NaN operand
//   overflow_o       result rounded to infinity
//
// Parameters
//   ALIGN_STEP  bits shifted per ALIGN cycle (1, 2, 4 or 8)
//   MAX_SHIFT   exponent distance at which the smaller operand becomes sticky
// ----------------------------------------------------------------------------
module fpu_add_seq import fpu_pkg::*; #(
    parameter int ALIGN_STEP = 1,
    parameter int MAX_SHIFT  = 26
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    input  logic        sub_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic        invalid_o,
    output logic        overflow_o
);

    localparam logic [7:0] STEP_C      = 8'(ALIGN_STEP);
    localparam logic [7:0] MAX_SHIFT_C = 8'(MAX_SHIFT);
    localparam int         HID         = ALN_W - 1;   // hidden-bit position in sum

    // ---------------------------------------------------------------- state
    seq_state_t       state_q,    state_d;
    fp32_t            x_q,        x_d;
    fp32_t            y_q,        y_d;
    logic [ALN_W-1:0] big_q,      big_d;
    logic [ALN_W-1:0] small_q,    small_d;
    logic [7:0]       cnt_q,      cnt_d;
    logic             loaded_q,   loaded_d;
    logic [8:0]       exp_q,      exp_d;
    logic             sign_q,     sign_d;
    logic [SUM_W-1:0] sum_q,      sum_d;
    logic [31:0]      result_q,   result_d;
    logic             invalid_q,  invalid_d;
    logic             overflow_q, overflow_d;

    // ---------------------------------------------------------------- parser
    fp32_t      x_dec, y_dec, big_f, small_f;
    logic       x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_greater;
    logic [7:0] exp_shift;

    operands u_operands (
        .x_i         (x_q),
        .y_i         (y_q),
        .x_o         (x_dec),
        .y_o         (y_dec),
        .x_zero_o    (x_zero),
        .y_zero_o    (y_zero),
        .x_inf_o     (x_inf),
        .y_inf_o     (y_inf),
        .x_nan_o     (x_nan),
        .y_nan_o     (y_nan),
        .x_greater_o (x_greater),
        .exp_shift_o (exp_shift)
    );

    assign big_f   = x_greater ? x_dec : y_dec;
    assign small_f = x_greater ? y_dec : x_dec;

    // ---------------------------------------------------------------- datapath helpers
    logic             eff_sub;
    logic [7:0]       step;
    logic [ALN_W-1:0] lost_mask;
    logic [ALN_W-1:0] small_shr;
    logic [SUM_W-1:0] add_res;
    logic             round_up;
    logic [MANT_W:0]  mant_r;
    logic [8:0]       exp_r;
    logic [22:0]      frac_r;
    logic             accept_special;

    // y already carries the sub_i sign flip, so unlike signs mean a true subtract.
    assign eff_sub = x_dec.sign ^ y_dec.sign;

    // Right shift by min(ALIGN_STEP, remaining); shifted-out bits fold into sticky.
    assign step      = (cnt_q < STEP_C) ? cnt_q : STEP_C;
    assign lost_mask = (ALN_W'(1) << step) - ALN_W'(1);
    assign small_shr = (small_q >> step) | {{(ALN_W-1){1'b0}}, |(small_q & lost_mask)};

    // big_q always holds the larger magnitude, so the difference never goes negative.
    assign add_res = eff_sub ? ({1'b0, big_q} - {1'b0, small_q})
                             : ({1'b0, big_q} + {1'b0, small_q});

    // Nearest-even: round up when G is set and (R | S | LSB).
    assign round_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
    assign mant_r   = {1'b0, sum_q[HID:GRS_W]} + {{MANT_W{1'b0}}, round_up};
    assign exp_r    = exp_q + {8'd0, mant_r[MANT_W]};
    assign frac_r   = mant_r[MANT_W] ? mant_r[23:1] : mant_r[22:0];

    assign accept_special = (x_i[30:23] == EXP_INF) || (x_i[30:23] == 8'h00) ||
                            (y_i[30:23] == EXP_INF) || (y_i[30:23] == 8'h00);

    // ---------------------------------------------------------------- next state
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        big_d      = big_q;
        small_d    = small_q;
        cnt_d      = cnt_q;
        loaded_d   = loaded_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        sum_d      = sum_q;
        result_d   = result_q;
        invalid_d  = invalid_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    x_d        = x_i;
                    y_d        = y_i ^ {sub_i, 31'd0};
                    loaded_d   = 1'b0;
                    invalid_d  = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = accept_special ? SPECIAL : ALIGN;
                end
            end

            SPECIAL: begin
                if (x_nan || y_nan) begin
                    result_d  = QNAN;
                    invalid_d = 1'b1;
                end else if (x_inf && y_inf && eff_sub) begin
                    result_d  = QNAN;
                    invalid_d = 1'b1;
                end else if (x_inf) begin
                    result_d = x_q;
                end else if (y_inf) begin
                    result_d = y_q;
                end else if (x_zero && y_zero) begin
                    // -0 only when both are -0.
                    result_d = {x_dec.sign & y_dec.sign, 31'd0};
                end else if (x_zero) begin
                    result_d = y_q;
                end else begin
                    result_d = x_q;
                end
                state_d = DONE;
            end

            ALIGN: begin
                if (!loaded_q) begin
                    // First ALIGN cycle: load significands and the shift distance.
                    loaded_d = 1'b1;
                    sign_d   = big_f.sign;
                    exp_d    = {1'b0, big_f.exp};
                    big_d    = aligned_mant(big_f);
                    if (exp_shift >= MAX_SHIFT_C) begin
                        // Entirely below the sticky position: only its non-zero-ness matters.
                        small_d = ALN_W'(1);
                        cnt_d   = 8'd0;
                        state_d = ADD;
                    end else begin
                        small_d = aligned_mant(small_f);
                        cnt_d   = exp_shift;
                        if (exp_shift == 8'd0) begin
                            state_d = ADD;
                        end
                    end
                end else begin
                    small_d = small_shr;
                    cnt_d   = cnt_q - step;
                    if (cnt_q == step) begin
                        state_d = ADD;
                    end
                end
            end

            ADD: begin
                if (add_res == '0) begin
                    // Exact cancellation is +0 regardless of operand signs.
                    result_d = 32'd0;
                    state_d  = DONE;
                end else begin
                    sum_d   = add_res;
                    state_d = NORM;
                end
            end

            NORM: begin
                if (sum_q[SUM_W-1]) begin
                    sum_d   = {1'b0, sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + 9'd1;
                    state_d = ROUND;
                end else if (sum_q[HID]) begin
                    state_d = ROUND;
                end else if (exp_q == 9'd1) begin
                    // One more left shift would need exponent 0: flush, no denormals.
                    result_d = {sign_q, 31'd0};
                    state_d  = DONE;
                end else begin
                    sum_d = {sum_q[SUM_W-2:0], 1'b0};
                    exp_d = exp_q - 9'd1;
                end
            end

            ROUND: begin
                if (exp_r >= {1'b0, EXP_INF}) begin
                    result_d   = {sign_q, EXP_INF, 23'd0};
                    overflow_d = 1'b1;
                end else begin
                    result_d = {sign_q, exp_r[7:0], frac_r};
                end
                state_d = DONE;
            end

            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- registers
    // NOTE: the datapath registers are reset too, so an operation interrupted by reset leaves nothing behind.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            big_q      <= '0;
            small_q    <= '0;
            cnt_q      <= '0;
            loaded_q   <= 1'b0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            sum_q      <= '0;
            result_q   <= '0;
            invalid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the values from before this edge.
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            big_q      <= big_d;
            small_q    <= small_d;
            cnt_q      <= cnt_d;
            loaded_q   <= loaded_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            sum_q      <= sum_d;
            result_q   <= result_d;
            invalid_q  <= invalid_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign result_o    = result_q;
    assign invalid_o   = invalid_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_fpu_add_seq.sv
// ----------------------------------------------------------------------------
// tb_fpu_add_seq
// Directed cases, backpressure, mid-operation reset and randomized operands
// compared against an exact-integer model of fp32 add with nearest-even
// rounding, flush-to-zero inputs/outputs and the special-case priority list.
// ----------------------------------------------------------------------------
module tb_fpu_add_seq;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] x_i;
    logic [31:0] y_i;
    logic        sub_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        invalid_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;

    fpu_add_seq #(.ALIGN_STEP(1), .MAX_SHIFT(26)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .x_i         (x_i),
        .y_i         (y_i),
        .sub_i       (sub_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .invalid_o   (invalid_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    function automatic void ref_add(input logic [31:0] x, input logic [31:0] y_raw, input logic sub,
                                    output logic [31:0] r, output logic inv, output logic ovf);
        logic [31:0] y;
        int ex, ey, d, emin, p, e, sh;
        longint ma, mb, s;
        longint unsigned m, q, rem, half;
        logic sgn;
        y   = y_raw ^ {sub, 31'd0};
        ex  = int'(x[30:23]);
        ey  = int'(y[30:23]);
        inv = 1'b0;
        ovf = 1'b0;
        r   = 32'd0;
        if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) begin
            r = 32'h7FC0_0000; inv = 1'b1;
        end else if (ex == 255 && ey == 255 && x[31] != y[31]) begin
            r = 32'h7FC0_0000; inv = 1'b1;
        end else if (ex == 255) begin
            r = x;
        end else if (ey == 255) begin
            r = y;
        end else if (ex == 0 && ey == 0) begin
            r = {x[31] & y[31], 31'd0};
        end else if (ex == 0) begin
            r = y;
        end else if (ey == 0) begin
            r = x;
        end else begin
            // Exact sum in units of 2^(emin-150); a far-away operand only needs to be non-zero.
            ma = longint'({1'b1, x[22:0]});
            mb = longint'({1'b1, y[22:0]});
            if (ex >= ey) begin
                d = ex - ey;
                if (d > 32) begin ma = ma <<< 32; mb = 1; emin = ex - 32; end
                else        begin ma = ma <<< d;           emin = ey;      end
            end else begin
                d = ey - ex;
                if (d > 32) begin mb = mb <<< 32; ma = 1; emin = ey - 32; end
                else        begin mb = mb <<< d;           emin = ex;      end
            end
            s = (x[31] ? -ma : ma) + (y[31] ? -mb : mb);
            if (s == 0) begin
                r = 32'd0;
            end else begin
                sgn = (s < 0);
                m   = sgn ? longint'(-s) : longint'(s);
                p   = 0;
                for (int i = 0; i < 64; i++) if (m[i]) p = i;
                e = emin + p - 23;
                if (e <= 0) begin
                    r = {sgn, 31'd0};
                end else begin
                    if (p > 23) begin
                        sh   = p - 23;
                        q    = m >> sh;
                        rem  = m & ((64'd1 << sh) - 64'd1);
                        half = 64'd1 << (sh - 1);
                        if (rem > half || (rem == half && q[0])) q = q + 1;
                        if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
                    end else begin
                        q = m << (23 - p);
                    end
                    if (e >= 255) begin
                        r = {sgn, 8'hFF, 23'd0}; ovf = 1'b1;
                    end else begin
                        r = {sgn, 8'(e), q[22:0]};
                    end
                end
            end
        end
    endfunction

    // ---------------------------------------------------------------- stimulus helpers
    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic sub);
        @(negedge clk_i);
        x_i = x; y_i = y; sub_i = sub; in_valid_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    // Counts rising edges from the accepting edge until out_valid_o is seen.
    task automatic wait_result(output int lat);
        lat = 1;
        while (out_valid_o !== 1'b1 && lat < 300) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic take_result();
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
    endtask

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic sub,
                         input logic [31:0] er, input logic ei, input logic eo,
                         input int elat, input string tag);
        int lat;
        start_op(x, y, sub);
        wait_result(lat);
        if (out_valid_o === 1'b1) begin
            check({tag, "_result"},   result_o,   er);
            check({tag, "_invalid"},  invalid_o,  ei);
            check({tag, "_overflow"}, overflow_o, eo);
            if (elat > 0) check({tag, "_latency"}, lat, elat);
        end else begin
            check({tag, "_timeout"}, out_valid_o, 1);
        end
        take_result();
    endtask

    function automatic logic [31:0] rand_fp(input logic [7:0] near);
        int k, e;
        logic s;
        logic [22:0] f;
        k = int'($urandom_range(0, 99));
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        e = int'(near) + int'($urandom_range(0, 60)) - 30;
        if (e < 1)   e = 1;
        if (e > 254) e = 254;
        if (k < 4)       return {s, 31'd0};
        else if (k < 7)  return {s, 8'hFF, 23'd0};
        else if (k < 9)  return {s, 8'hFF, f | 23'd1};
        else if (k < 12) return {s, 8'h00, f | 23'd1};
        else if (k < 20) return {s, 8'($urandom_range(1, 254)), f};
        else if (k < 26) return {s, 8'($urandom_range(250, 254)), f};
        else if (k < 30) return {s, 8'($urandom_range(1, 4)), f};
        else             return {s, 8'(e), f};
    endfunction

    // ---------------------------------------------------------------- test sequence
    initial begin
        logic [31:0] xr, yr, er;
        logic        sb, ei, eo, seen;
        int          lat;

        rst_n_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        x_i = '0; y_i = '0; sub_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_in_ready",  in_ready_o,  1);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_result",    result_o,    0);
        check("rst_invalid",   invalid_o,   0);
        check("rst_overflow",  overflow_o,  0);
        rst_n_i = 1'b1;

        // Directed cases.
        do_op(32'h3FC0_0000, 32'h4000_0000, 1'b0, 32'h4060_0000, 0, 0, 6, "add_3p5");
        do_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 0, 0, 0, "sub_zero");
        do_op(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 0, 0, 0, "tie_even");
        do_op(32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001, 0, 0, 0, "above_tie");
        do_op(32'h7F80_0000, 32'hBAA3_D70A, 1'b0, 32'h7F80_0000, 0, 0, 2, "inf_plus_num");
        do_op(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 1, 0, 2, "inf_minus_inf");
        do_op(32'h7FFF_FFFF, 32'hC0C2_8F5C, 1'b0, 32'h7FC0_0000, 1, 0, 2, "nan_operand");
        do_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 0, 1, 0, "overflow");
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 0, 0, 2, "negzero_sum");
        do_op(32'h4000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 0, 0, 2, "num_minus_zero");

        // Backpressure: result held while the consumer stalls; new requests ignored.
        start_op(32'h3FC0_0000, 32'h4000_0000, 1'b0);
        wait_result(lat);
        check("bp_first_valid", out_valid_o, 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin x_i = 32'h4120_0000; y_i = 32'h4120_0000; in_valid_i = 1'b1; end
            if (i == 4) in_valid_i = 1'b0;
            @(negedge clk_i);
            check("bp_valid",    out_valid_o, 1);
            check("bp_result",   result_o,    32'h4060_0000);
            check("bp_invalid",  invalid_o,   0);
            check("bp_overflow", overflow_o,  0);
            check("bp_in_ready", in_ready_o,  0);
        end
        // Release with in_valid_i still high: it must not be taken on the release edge.
        out_ready_i = 1'b1; in_valid_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0; in_valid_i = 1'b0;
        check("bp_release_in_ready",  in_ready_o,  1);
        check("bp_release_out_valid", out_valid_o, 0);
        repeat (3) @(negedge clk_i);
        check("bp_idle_in_ready",  in_ready_o,  1);
        check("bp_idle_out_valid", out_valid_o, 0);

        // Asynchronous reset in the middle of ALIGN.
        start_op(32'h3F80_0000, 32'h3380_0000, 1'b0);
        repeat (3) @(negedge clk_i);
        check("pre_rst_busy", in_ready_o, 0);
        #2 rst_n_i = 1'b0;
        #1;
        check("mid_rst_in_ready",  in_ready_o,  1);
        check("mid_rst_out_valid", out_valid_o, 0);
        check("mid_rst_result",    result_o,    0);
        check("mid_rst_invalid",   invalid_o,   0);
        check("mid_rst_overflow",  overflow_o,  0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk_i);
            if (out_valid_o) seen = 1'b1;
        end
        check("post_rst_no_stale", seen, 0);
        check("post_rst_in_ready", in_ready_o, 1);
        do_op(32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001, 0, 0, 0, "post_rst_op");

        // Randomized operands against the model.
        for (int n = 0; n < 300; n++) begin
            xr = rand_fp(8'($urandom_range(1, 254)));
            if ($urandom_range(0, 99) < 15)
                yr = {xr[31], xr[30:23], xr[22:0] ^ 23'($urandom_range(0, 15))};
            else
                yr = rand_fp(xr[30:23]);
            sb = 1'($urandom_range(0, 1));
            ref_add(xr, yr, sb, er, ei, eo);
            do_op(xr, yr, sb, er, ei, eo, 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
